// File: rtl/pagerank_pkg.sv
// pagerank_pkg: shared defaults and arithmetic helpers; PAGERANK_MR_SATURATE_EN selects saturating arithmetic
package pagerank_pkg;
  localparam int NBITS_DEF = 32;
  localparam int FRAC_BITS_DEF = 16;
  localparam int NUM_MAPPERS_DEF = 4;
  localparam int CNT_BITS_DEF = 16;
  localparam int MAX_W = 64;
  localparam int MAX_BUS = 2048;
`ifdef PAGERANK_MR_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  function automatic logic [MAX_W-1:0] lane_slice(input logic [MAX_BUS-1:0] bus, input int i, input int w);
    return MAX_W'(bus >> (i * w)) & ({MAX_W{1'b1}} >> (MAX_W - w));
  endfunction
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b, input int w);
    logic [MAX_W:0] s;
    logic [MAX_W:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = {1'b0, {MAX_W{1'b1}} >> (MAX_W - w)};
    return MAX_W'((SAT_EN && s > m) ? m : s & m);
  endfunction
endpackage

// File: rtl/pagerank_mapreduce_core_if.sv
// pagerank_mapreduce_core_if: beat input and row result handshakes between scheduler and core
interface pagerank_mapreduce_core_if import pagerank_pkg::*; #(
  parameter int NBITS = NBITS_DEF,
  parameter int NUM_MAPPERS = NUM_MAPPERS_DEF,
  parameter int CNT_BITS = CNT_BITS_DEF
);
  logic in_val;
  logic in_rdy;
  logic [NUM_MAPPERS*NBITS-1:0] in_r;
  logic [NUM_MAPPERS*NBITS-1:0] in_g;
  logic [NUM_MAPPERS-1:0] in_mask;
  logic in_last;
  logic out_val;
  logic out_rdy;
  logic [NBITS-1:0] out_result;
  logic [CNT_BITS-1:0] out_nbeats;
  modport master(output in_val, in_r, in_g, in_mask, in_last, out_rdy, input in_rdy, out_val, out_result, out_nbeats);
  modport slave(input in_val, in_r, in_g, in_mask, in_last, out_rdy, output in_rdy, out_val, out_result, out_nbeats);
endinterface

// File: rtl/pagerank_mapper_lane.sv
// pagerank_mapper_lane: one lane's masked fixed-point multiply with registered product
module pagerank_mapper_lane import pagerank_pkg::*; #(
  parameter int NBITS = NBITS_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic m,
  input  logic [NBITS-1:0] r,
  input  logic [NBITS-1:0] g,
  output logic [NBITS-1:0] p
);
  logic [2*NBITS-1:0] f;
  logic [NBITS-1:0] q;
  // full product rescaled, then masked and truncated or clamped
  always_comb begin
    f = ({{NBITS{1'b0}}, r} * {{NBITS{1'b0}}, g}) >> FRAC_BITS;
    q = !m ? '0 : (SAT_EN && |f[2*NBITS-1:NBITS]) ? '1 : f[NBITS-1:0];
  end
  // S1 product register, held while the output is stalled
  always_ff @(posedge clk)
    if (reset) p <= '0;
    else if (en) p <= q;
endmodule

// File: rtl/pagerank_mapreduce_core.sv
// pagerank_mapreduce_core: lane multiply, adder-tree reduce and per-row accumulate; PAGERANK_MR_SATURATE_EN saturates
module pagerank_mapreduce_core import pagerank_pkg::*; #(
  parameter int NBITS = NBITS_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int NUM_MAPPERS = NUM_MAPPERS_DEF,
  parameter int CNT_BITS = CNT_BITS_DEF
) (
  input logic clk,
  input logic reset,
  pagerank_mapreduce_core_if.slave bus
);
  logic stall, rdy_q, val1, last1, fire;
  logic [NBITS-1:0] t [2*NUM_MAPPERS-1];
  logic [NBITS-1:0] acc, acc_n;
  logic [CNT_BITS-1:0] cnt, cnt_n;
  assign stall = bus.out_val && !bus.out_rdy;
  assign bus.in_rdy = rdy_q && !stall && !reset;
  assign fire = val1 && !stall;
  genvar i;
  generate
    for (i = 0; i < NUM_MAPPERS; i++) begin : g_lane
      pagerank_mapper_lane #(.NBITS(NBITS), .FRAC_BITS(FRAC_BITS)) u_lane (
        .clk(clk),
        .reset(reset),
        .en(!stall),
        .m(bus.in_mask[i]),
        .r(NBITS'(lane_slice(MAX_BUS'(bus.in_r), i, NBITS))),
        .g(NBITS'(lane_slice(MAX_BUS'(bus.in_g), i, NBITS))),
        .p(t[NUM_MAPPERS-1+i])
      );
    end
    for (i = 0; i < NUM_MAPPERS - 1; i++) begin : g_tree
      assign t[i] = NBITS'(sat_add(MAX_W'(t[2*i+1]), MAX_W'(t[2*i+2]), NBITS));
    end
  endgenerate
  // next accumulator and saturating beat count
  always_comb begin
    acc_n = NBITS'(sat_add(MAX_W'(acc), MAX_W'(t[0]), NBITS));
    cnt_n = &cnt ? cnt : cnt + CNT_BITS'(1);
  end
  // S1 valid/last alongside the lane product registers
  always_ff @(posedge clk)
    if (reset) begin
      val1 <= 1'b0;
      last1 <= 1'b0;
    end else if (!stall) begin
      val1 <= bus.in_val && bus.in_rdy;
      last1 <= bus.in_last;
    end
  // S2 accumulate and registered row result
  always_ff @(posedge clk)
    if (reset) begin
      rdy_q <= 1'b0;
      acc <= '0;
      cnt <= '0;
      bus.out_val <= 1'b0;
      bus.out_result <= '0;
      bus.out_nbeats <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (!stall) bus.out_val <= val1 && last1;
      if (fire && last1) begin
        bus.out_result <= acc_n;
        bus.out_nbeats <= cnt_n;
        acc <= '0;
        cnt <= '0;
      end else if (fire) begin
        acc <= acc_n;
        cnt <= cnt_n;
      end
    end
endmodule

// File: tb/tb_pagerank_mapreduce_core.sv
// tb_pagerank_mapreduce_core: scoreboard bench for the map-reduce row datapath
module tb_pagerank_mapreduce_core;
  localparam int NB = 32;
  localparam int NM = 4;
  localparam int CB = 16;
`ifdef PAGERANK_MR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] res;
    logic [15:0] nb;
  } res_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  res_t sb[$];
  res_t e;
  logic [63:0] acc_m = 0;
  int cnt_m = 0;
  pagerank_mapreduce_core_if #(.NBITS(NB), .NUM_MAPPERS(NM), .CNT_BITS(CB)) bus();
  pagerank_mapreduce_core #(.NBITS(NB), .FRAC_BITS(16), .NUM_MAPPERS(NM), .CNT_BITS(CB)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] fix(input logic [63:0] v);
    return SAT ? (v > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : v) : (v & 64'hFFFF_FFFF);
  endfunction
  function automatic logic [63:0] beat_sum(input logic [127:0] r, input logic [127:0] g, input logic [3:0] m);
    logic [63:0] s;
    s = 0;
    for (int i = 0; i < NM; i++)
      if (m[i]) s = s + fix((64'(r[i*32 +: 32]) * 64'(g[i*32 +: 32])) >> 16);
    return fix(s);
  endfunction
  task automatic send_beat(input logic [127:0] r, input logic [127:0] g, input logic [3:0] m, input logic l);
    bus.in_val = 1'b1;
    bus.in_r = r;
    bus.in_g = g;
    bus.in_mask = m;
    bus.in_last = l;
    for (int k = 0; k < 200; k++) begin
      if (k >= 8) bus.out_rdy = 1'b1;
      @(negedge clk);
      if (bus.in_rdy) begin
        acc_m = fix(acc_m + beat_sum(r, g, m));
        cnt_m = cnt_m < 65535 ? cnt_m + 1 : cnt_m;
        if (l) begin
          sb.push_back(res_t'({acc_m[31:0], 16'(cnt_m)}));
          acc_m = 0;
          cnt_m = 0;
        end
        @(posedge clk);
        #1;
        bus.in_val = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("accept_timeout", bus.in_rdy, 1);
    bus.in_val = 1'b0;
  endtask
  task automatic wait_drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (!reset && bus.out_val && bus.out_rdy) begin
      if (sb.size() == 0) check("unexpected_out", bus.out_val, 0);
      else begin
        e = sb.pop_front();
        check("result", bus.out_result, e.res);
        check("nbeats", bus.out_nbeats, e.nb);
      end
    end
  initial begin
    bus.in_val = 1'b0;
    bus.in_r = '0;
    bus.in_g = '0;
    bus.in_mask = '0;
    bus.in_last = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_rdy", bus.in_rdy, 0);
    check("rst_out_val", bus.out_val, 0);
    check("rst_out_result", bus.out_result, 0);
    check("rst_out_nbeats", bus.out_nbeats, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rdy_after_reset", bus.in_rdy, 1);
    @(posedge clk);
    #1;
    send_beat({4{32'h0001_0000}}, {4{32'h0000_8000}}, 4'hF, 1'b1);
    @(negedge clk);
    check("lat_t1_val", bus.out_val, 0);
    @(negedge clk);
    check("lat_t2_val", bus.out_val, 1);
    check("single_result", bus.out_result, 32'h0002_0000);
    check("single_nbeats", bus.out_nbeats, 1);
    @(posedge clk);
    #1;
    for (int b = 0; b < 3; b++) send_beat({4{32'h0001_0000}}, {4{32'h0000_4000}}, 4'hF, b == 2);
    send_beat({4{32'h0001_0000}}, {4{32'h0001_0000}}, 4'b0101, 1'b1);
    wait_drain();
    bus.out_rdy = 1'b0;
    send_beat({4{32'h0001_0000}}, {4{32'h0001_0000}}, 4'hF, 1'b1);
    send_beat({4{32'h0001_0000}}, {4{32'h0001_0000}}, 4'h1, 1'b1);
    repeat (5) @(negedge clk);
    check("stall_in_rdy", bus.in_rdy, 0);
    check("stall_out_val", bus.out_val, 1);
    check("stall_result", bus.out_result, 32'h0004_0000);
    check("stall_nbeats", bus.out_nbeats, 1);
    @(posedge clk);
    #1;
    bus.out_rdy = 1'b1;
    wait_drain();
    send_beat({4{32'hFFFF_0000}}, {4{32'hFFFF_0000}}, 4'hF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("overflow", bus.out_result, SAT ? 32'hFFFF_FFFF : 32'h0004_0000);
    @(posedge clk);
    #1;
    wait_drain();
    send_beat({4{32'h0001_0000}}, {4{32'h0001_0000}}, 4'hF, 1'b0);
    send_beat({4{32'h0001_0000}}, {4{32'h0001_0000}}, 4'hF, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    acc_m = 0;
    cnt_m = 0;
    send_beat({4{32'h0001_0000}}, {4{32'h0001_0000}}, 4'h1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("post_reset_result", bus.out_result, 32'h0001_0000);
    check("post_reset_nbeats", bus.out_nbeats, 1);
    @(posedge clk);
    #1;
    for (int n = 0; n < 20; n++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        bus.out_rdy = $urandom_range(0, 3) != 0;
        send_beat({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                  4'($urandom_range(0, 15)), b == len - 1);
      end
    end
    bus.out_rdy = 1'b1;
    wait_drain();
    repeat (3) @(negedge clk);
    check("queue_empty", sb.size(), 0);
    check("idle_out_val", bus.out_val, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pagerank_mapreduce_core.md
# pagerank_mapreduce_core

Parametrised, pipelined map-reduce datapath for PageRank row evaluation. Each beat accepts one (rank, weight) fixed-point pair per mapper lane, multiplies lane-wise, reduces the lanes through an adder tree and accumulates across beats until a beat flagged last, then emits one row result. Sits between the scheduler, which streams rank/weight beats fetched from memory, and the scheduler's result write-back path. It generalises the fixed 4-mapper/1-reducer arrangement to any lane count, with full val/rdy flow control, partial-beat masking and a per-row beat count.

## Interface
- NBITS, 32, width of rank, weight, product and result (unsigned fixed point)
- FRAC_BITS, 16, fractional bits of the fixed-point format; 0 ≤ FRAC_BITS < NBITS
- NUM_MAPPERS, 4, lanes per beat; power of two, 1..32
- CNT_BITS, 16, width of the beat counter

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- in_val  in  1  input beat valid
- in_rdy  out  1  input beat ready
- in_r  in  NUM_MAPPERS*NBITS  lane i rank at bits [i*NBITS +: NBITS]
- in_g  in  NUM_MAPPERS*NBITS  lane i weight, same packing
- in_mask  in  NUM_MAPPERS  1 = lane contributes; 0 = lane forced to zero
- in_last  in  1  final beat of the current row
- out_val  out  1  row result valid
- out_rdy  in  1  row result ready
- out_result  out  NBITS  accumulated row sum
- out_nbeats  out  CNT_BITS  beats accepted for this row

## Operation
- Transfer on any interface occurs in a cycle where val && rdy.
- Stage S1 (registered): per lane p_i = in_mask[i] ? (in_r_i * in_g_i) >> FRAC_BITS : 0, truncated to NBITS. S1 also registers val1 and last1.
- Stage S2 (accumulate): sum = adder tree over the S1 products. When val1: if last1, out_result <= acc + sum, out_nbeats <= cnt + 1, out_val <= 1, acc <= 0, cnt <= 0; else acc <= acc + sum, cnt <= cnt + 1.
- cnt saturates at 2^CNT_BITS-1 and never wraps.
- Arithmetic without the configuration macro is modulo 2^NBITS at every stage: products truncate and sums wrap.
- stall = out_val && !out_rdy. While stalled, S1, acc and cnt hold and in_rdy = 0. Otherwise in_rdy = 1.
- A row of one beat is legal (in_last on the first beat).
- A beat with in_mask all zero still counts toward out_nbeats.
- A beat is accepted regardless of whether a previous row is still in flight, so rows pipeline back-to-back with no bubble.

## Timing
- Reset values: in_rdy = 1 from the cycle after reset is deasserted. During reset, in_rdy = 0, out_val = 0, out_result = 0, out_nbeats = 0. Reset also clears acc, cnt and val1.
- Latency: a last beat accepted in cycle t gives out_val = 1 in cycle t+2 when out_rdy stays high.
- Throughput: one beat per cycle.
- Output clear: out_val drops the cycle after out_val && out_rdy, unless another last beat completes S2 in that same cycle. In that case out_val stays 1 with the new result.
- out_result and out_nbeats are stable while out_val && !out_rdy.
- Reset mid-row discards the partial accumulation and any beat in S1. A pending result is dropped.

## Configuration
- PAGERANK_MR_SATURATE_EN:
  - Defined: lane products, tree sums and the accumulator saturate at 2^NBITS-1 instead of wrapping. Saturation is sticky for the row and clears when acc clears.
  - Undefined: all arithmetic is modulo 2^NBITS, as in Operation.

## Structure
- The shared package pagerank_pkg holds:
  - default parameter constants (NBITS, FRAC_BITS, NUM_MAPPERS, CNT_BITS);
  - the lane-slicing helper function;
  - the saturating-add function, used by both the tree and the accumulator.
- Sub-module pagerank_mapper_lane: one lane's masked fixed-point multiply, with the S1 product register. It is instantiated NUM_MAPPERS times in a generate loop.
- The adder tree, S2 accumulator and output register live in the top.

## Test plan
All scenarios use NBITS=32 and FRAC_BITS=16.
- Single-beat row: NUM_MAPPERS=4, r=0x0001_0000 and g=0x0000_8000 on all lanes, mask=0xF, last=1 → out_result=0x0002_0000, out_nbeats=1, out_val at t+2.
- Three-beat row: r=0x0001_0000 on all lanes; g=0x0000_4000 per lane on every beat, mask=0xF; last on beat 3 → out_result=0x0003_0000, out_nbeats=3.
- Mask: single-beat row with mask=0b0101, all r=g=0x0001_0000 → out_result=0x0002_0000, out_nbeats=1.
- Backpressure: two back-to-back single-beat rows with out_rdy held low for 5 cycles → in_rdy low while stalled, both results delivered in order, no beat lost or duplicated.
- Overflow: with NUM_MAPPERS=4, all lanes r=g=0xFFFF_0000, mask=0xF, last=1 → with PAGERANK_MR_SATURATE_EN, out_result=0xFFFF_FFFF; without it, the truncated modular sum.
- Reset mid-row: 2 beats of a row accepted, reset asserted for 1 cycle, then a new single-beat row of value 0x0001_0000 → out_result=0x0001_0000, out_nbeats=1.
